// File: rtl/ccip_arb_pkg.sv
// Shared arbiter types plus a minimal CCI-P c1 subset (mirrors platform_if.vh) so this slice builds standalone.
package ccip_arb_pkg;
  localparam int MAX_ARB_REQ = 8;

  typedef enum logic {ArbIdle, ArbBurst} ArbState;
  typedef logic [1:0] BurstCnt;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1
  } t_ccip_c1_req;

  typedef struct packed {
    logic [5:0]   rsvd1;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd0;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd2;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational find-first-set over an eligibility vector, starting at a rotating index and wrapping.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int LN = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [LN-1:0] start,
  output logic          valid,
  output logic [LN-1:0] index
);
  int pos;

  // Scan from the farthest offset down so the nearest eligible slot wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(start) + k) % N;
      if (eligible[pos]) begin
        valid = 1'b1;
        index = LN'(pos);
      end
    end
  end
endmodule

// File: rtl/ccip_c1_arbiter.sv
// Burst-atomic round-robin arbiter sharing the CCI-P c1 write channel among NUM_REQ requesters.
// Optional per-requester beat / stall counters are built when CCIP_C1_ARB_STATS_EN is defined.
module ccip_c1_arbiter
  import ccip_arb_pkg::*;
#(
  parameter int NIC_ID   = 0,
  parameter int NUM_REQ  = 2,
  parameter int LNUM_REQ = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sRx_c1TxAlmFull,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  t_if_ccip_c1_Tx      req_tx [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_ready,
  output t_if_ccip_c1_Tx      sTx_c1,
  output logic                error,
  output logic [LNUM_REQ-1:0] grant_id_out,
  output ArbState             arb_state
`ifdef CCIP_C1_ARB_STATS_EN
  ,
  output logic [31:0]         stat_beats_out [NUM_REQ],
  output logic [31:0]         stat_stall_out
`endif
);
  if (NUM_REQ < 2 || NUM_REQ > MAX_ARB_REQ) begin : g_bad_cfg
    $error("ccip_c1_arbiter NIC %0d: NUM_REQ=%0d out of range", NIC_ID, NUM_REQ);
  end

  ArbState             state;
  BurstCnt             beats_left;
  logic [LNUM_REQ-1:0] owner, rr_ptr;
  logic [NUM_REQ-1:0]  sop_vec, unused_tx_valid;
  logic                pick_valid;
  logic [LNUM_REQ-1:0] pick_idx, acc_idx;
  logic                accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sop
    assign sop_vec[g]         = req_tx[g].hdr.sop;
    assign unused_tx_valid[g] = req_tx[g].valid;
  end

  rr_priority_picker #(.N(NUM_REQ), .LN(LNUM_REQ)) u_picker (
    .eligible (req_valid & sop_vec),
    .start    (rr_ptr),
    .valid    (pick_valid),
    .index    (pick_idx)
  );

  // Handshake: a beat moves on requester i in any cycle where req_valid[i] && req_ready[i].
  // req_ready never depends on the requester waiting for it, so valid may rise independently.
  always_comb begin
    req_ready = '0;
    if (!reset && !sRx_c1TxAlmFull) begin
      if (state == ArbIdle) begin
        if (pick_valid) req_ready[pick_idx] = 1'b1;
      end else begin
        req_ready[owner] = req_valid[owner];
      end
    end
  end

  assign accept       = |(req_valid & req_ready);
  assign acc_idx      = (state == ArbIdle) ? pick_idx : owner;
  assign grant_id_out = owner;
  assign arb_state    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ArbIdle;
      rr_ptr     <= '0;
      beats_left <= '0;
      owner      <= '0;
      sTx_c1     <= '0;
      error      <= 1'b0;
    end else begin
      sTx_c1.valid <= accept;
      if (accept) begin
        sTx_c1.hdr  <= req_tx[acc_idx].hdr;
        sTx_c1.data <= req_tx[acc_idx].data;
      end
      // A mid-burst beat presented as a burst start can never be granted; flag it.
      if (!sRx_c1TxAlmFull && state == ArbIdle && |(req_valid & ~sop_vec)) error <= 1'b1;
      if (accept) begin
        if (state == ArbIdle) begin
          owner      <= pick_idx;
          rr_ptr     <= (pick_idx == LNUM_REQ'(NUM_REQ - 1)) ? '0 : pick_idx + LNUM_REQ'(1);
          beats_left <= BurstCnt'(req_tx[pick_idx].hdr.cl_len);
          if (req_tx[pick_idx].hdr.cl_len != eCL_LEN_1) state <= ArbBurst;
        end else begin
          if (req_tx[owner].hdr.sop) error <= 1'b1;
          beats_left <= beats_left - BurstCnt'(1);
          if (beats_left == BurstCnt'(1)) state <= ArbIdle;
        end
      end
    end
  end

`ifdef CCIP_C1_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) stat_beats_out[i] <= '0;
      stat_stall_out <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) stat_beats_out[i] <= stat_beats_out[i] + 32'd1;
      end
      if (|req_valid && sRx_c1TxAlmFull) stat_stall_out <= stat_stall_out + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ccip_c1_arbiter.sv
// Directed bench for ccip_c1_arbiter (NUM_REQ=2); the counter section is built with CCIP_C1_ARB_STATS_EN.
module tb_ccip_c1_arbiter;
  import ccip_arb_pkg::*;

  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           alm;
  logic [NR-1:0]  req_valid;
  t_if_ccip_c1_Tx req_tx [NR];
  logic [NR-1:0]  req_ready;
  t_if_ccip_c1_Tx sTx_c1;
  logic           error;
  logic [0:0]     grant_id_out;
  ArbState        arb_state;
`ifdef CCIP_C1_ARB_STATS_EN
  logic [31:0]    stat_beats_out [NR];
  logic [31:0]    stat_stall_out;
`endif

  ccip_c1_arbiter #(.NIC_ID(0), .NUM_REQ(NR), .LNUM_REQ(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .sRx_c1TxAlmFull (alm),
    .req_valid       (req_valid),
    .req_tx          (req_tx),
    .req_ready       (req_ready),
    .sTx_c1          (sTx_c1),
    .error           (error),
    .grant_id_out    (grant_id_out),
    .arb_state       (arb_state)
`ifdef CCIP_C1_ARB_STATS_EN
    ,
    .stat_beats_out  (stat_beats_out),
    .stat_stall_out  (stat_stall_out)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  t_if_ccip_c1_Tx rq0[$], rq1[$];
  logic [41:0]    exp_q[$];
  logic [41:0]    got[$];
  int             got_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic t_if_ccip_c1_Tx beat(input logic sop, input t_ccip_clLen cl, input logic [41:0] addr);
    t_if_ccip_c1_Tx b;
    b              = '0;
    b.hdr.sop      = sop;
    b.hdr.cl_len   = cl;
    b.hdr.req_type = eREQ_WRLINE_I;
    b.hdr.address  = addr;
    b.data         = {8{22'h0, addr}};
    b.valid        = 1'b1;
    return b;
  endfunction

  // Driver: present queue fronts, pop on handshake, record sTx_c1 addresses.
  task automatic run(input int ncyc, input int alm_from, input int alm_len);
    logic [NR-1:0] acc;
    t_if_ccip_c1_Tx dummy;
    for (int c = 0; c < ncyc; c++) begin
      alm          = (c >= alm_from) && (c < alm_from + alm_len);
      req_valid[0] = (rq0.size() > 0);
      req_valid[1] = (rq1.size() > 0);
      if (rq0.size() > 0) req_tx[0] = rq0[0];
      if (rq1.size() > 0) req_tx[1] = rq1[0];
      #1;
      chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      if (alm) chk("almfull_ready", 64'(req_ready), 64'd0);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (acc[0]) dummy = rq0.pop_front();
      if (acc[1]) dummy = rq1.pop_front();
      if (sTx_c1.valid) begin
        got.push_back(sTx_c1.hdr.address);
        got_cyc.push_back(c);
      end
      cyc++;
    end
    req_valid = '0;
    alm       = 1'b0;
  endtask

  // Scoreboard: compare recorded output order against the expected queue.
  task automatic compare_got(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      chk({tag, "_addr"}, (k < got.size()) ? 64'(got[k]) : 64'hdead, 64'(exp_q[k]));
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got.delete();
    got_cyc.delete();
  endtask

  initial begin
    reset     = 1'b1;
    alm       = 1'b0;
    req_valid = '0;
    req_tx[0] = beat(1'b1, eCL_LEN_1, 42'h1);
    req_tx[1] = beat(1'b1, eCL_LEN_1, 42'h2);

    // Reset behaviour: no grants while reset is high, registered outputs cleared.
    #2;
    req_valid = 2'b11;
    #1;
    chk("reset_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_valid", 64'(sTx_c1.valid), 64'd0);
    chk("reset_addr", 64'(sTx_c1.hdr.address), 64'd0);
    chk("reset_data", sTx_c1.data[63:0], 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_grant", 64'(grant_id_out), 64'd0);
    chk("reset_state", 64'(arb_state), 64'(ArbIdle));

    // Single-line contention: strict alternation, one beat per cycle.
    for (int i = 0; i < 3; i++) begin
      rq0.push_back(beat(1'b1, eCL_LEN_1, 42'h10 + 42'(i)));
      rq1.push_back(beat(1'b1, eCL_LEN_1, 42'h20 + 42'(i)));
    end
    exp_q = '{42'h10, 42'h20, 42'h11, 42'h21, 42'h12, 42'h22};
    run(8, 100, 0);
    compare_got("single_order");
    chk("single_span", (got_cyc.size() == 6) ? 64'(got_cyc[5] - got_cyc[0]) : 64'hdead, 64'd5);
    chk("single_error", 64'(error), 64'd0);
    chk("single_grant", 64'(grant_id_out), 64'd1);
    chk("single_data", sTx_c1.data[63:0], 64'h22);
    clear_sb();

    // Burst atomicity: req 0 4-line burst, req 1 waits then follows with no bubble.
    rq0.push_back(beat(1'b1, eCL_LEN_4, 42'h30));
    for (int i = 1; i < 4; i++) rq0.push_back(beat(1'b0, eCL_LEN_4, 42'h30 + 42'(i)));
    rq1.push_back(beat(1'b1, eCL_LEN_1, 42'h40));
    exp_q = '{42'h30, 42'h31, 42'h32, 42'h33, 42'h40};
    run(7, 100, 0);
    compare_got("burst_order");
    chk("burst_span", (got_cyc.size() == 5) ? 64'(got_cyc[4] - got_cyc[0]) : 64'hdead, 64'd4);
    chk("burst_error", 64'(error), 64'd0);
    chk("burst_grant", 64'(grant_id_out), 64'd1);
    chk("burst_state", 64'(arb_state), 64'(ArbIdle));
    clear_sb();

    // Almost-full for 5 cycles after beat 2 of a 4-line burst.
    rq0.push_back(beat(1'b1, eCL_LEN_4, 42'h50));
    for (int i = 1; i < 4; i++) rq0.push_back(beat(1'b0, eCL_LEN_4, 42'h50 + 42'(i)));
    exp_q = '{42'h50, 42'h51, 42'h52, 42'h53};
    run(12, 2, 5);
    compare_got("alm_order");
    chk("alm_resume_cycle", (got_cyc.size() == 4) ? 64'(got_cyc[2]) : 64'hdead, 64'd7);
    chk("alm_last_cycle", (got_cyc.size() == 4) ? 64'(got_cyc[3]) : 64'hdead, 64'd8);
    chk("alm_grant", 64'(grant_id_out), 64'd0);
    chk("alm_state", 64'(arb_state), 64'(ArbIdle));
    clear_sb();

    // Protocol error: req 1 presents a non-sop beat while idle.
    rq1.push_back(beat(1'b0, eCL_LEN_1, 42'h61));
    rq0.push_back(beat(1'b1, eCL_LEN_1, 42'h60));
    exp_q = '{42'h60};
    run(4, 100, 0);
    compare_got("proto_order");
    chk("proto_error", 64'(error), 64'd1);
    chk("proto_req1_pending", 64'(rq1.size()), 64'd1);
    chk("proto_grant", 64'(grant_id_out), 64'd0);
    rq1.delete();
    run(2, 100, 0);
    chk("proto_sticky", 64'(error), 64'd1);
    clear_sb();

    // Async reset mid-burst after 2 of 4 beats.
    rq0.push_back(beat(1'b1, eCL_LEN_4, 42'h70));
    for (int i = 1; i < 4; i++) rq0.push_back(beat(1'b0, eCL_LEN_4, 42'h70 + 42'(i)));
    exp_q = '{42'h70, 42'h71};
    run(2, 100, 0);
    compare_got("rst_pre_order");
    chk("rst_pre_state", 64'(arb_state), 64'(ArbBurst));
    chk("rst_pre_valid", 64'(sTx_c1.valid), 64'd1);
    req_valid[0] = 1'b1;
    req_tx[0]    = rq0[0];
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 64'(sTx_c1.valid), 64'd0);
    chk("rst_async_ready", 64'(req_ready), 64'd0);
    chk("rst_async_error", 64'(error), 64'd0);
    chk("rst_async_state", 64'(arb_state), 64'(ArbIdle));
    req_valid = '0;
    rq0.delete();
    clear_sb();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    rq0.push_back(beat(1'b1, eCL_LEN_1, 42'h90));
    rq1.push_back(beat(1'b1, eCL_LEN_1, 42'h91));
    exp_q = '{42'h90, 42'h91};
    run(3, 100, 0);
    compare_got("rst_post_order");
    chk("rst_post_error", 64'(error), 64'd0);
    clear_sb();

    // Req 1 alone with req 0 idle is granted immediately.
    rq1.push_back(beat(1'b1, eCL_LEN_1, 42'ha0));
    exp_q = '{42'ha0};
    run(2, 100, 0);
    compare_got("solo_order");
    chk("solo_span", (got_cyc.size() == 1) ? 64'(got_cyc[0]) : 64'hdead, 64'd0);
    chk("solo_grant", 64'(grant_id_out), 64'd1);
    clear_sb();

`ifdef CCIP_C1_ARB_STATS_EN
    // Counters: 3 stall cycles then 10 single-line beats from req 0.
    reset = 1'b1;
    #2;
    chk("stat_reset_beats", 64'(stat_beats_out[0]), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) rq0.push_back(beat(1'b1, eCL_LEN_1, 42'hb0 + 42'(i)));
    run(15, 0, 3);
    chk("stat_beats0", 64'(stat_beats_out[0]), 64'd10);
    chk("stat_beats1", 64'(stat_beats_out[1]), 64'd0);
    chk("stat_stall", 64'(stat_stall_out), 64'd3);
    clear_sb();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
